axi_bridge_arbiter: RTL

Shares one AXI3 master port between the CPU's instruction and data sram-like request interfaces. It sits between the IF and MEM stages and the AXI interconnect. It arbitrates the single read channel, with data reads taking priority over instruction reads. It tags reads with arid 0 for instruction and 1 for data, and sequences data-side writes through AW/W/B.

---
 rtl/axi_bridge_arbiter.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/axi_bridge_arbiter.sv
// axi_bridge_arbiter: shares one AXI3 master between inst/data sram-like ports; data reads win; RAW_CHECK_EN blocks reads that hit a pending write word
module axi_bridge_arbiter (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_req_i,
   input  logic        inst_sram_wr_i,
   input  logic [1:0]  inst_sram_size_i,
   input  logic [3:0]  inst_sram_wstrb_i,
   input  logic [31:0] inst_sram_addr_i,
   input  logic [31:0] inst_sram_wdata_i,
   output logic        inst_sram_addr_ok_o,
   output logic        inst_sram_data_ok_o,
   output logic [31:0] inst_sram_rdata_o,
   input  logic        data_sram_req_i,
   input  logic        data_sram_wr_i,
   input  logic [1:0]  data_sram_size_i,
   input  logic [3:0]  data_sram_wstrb_i,
   input  logic [31:0] data_sram_addr_i,
   input  logic [31:0] data_sram_wdata_i,
   output logic        data_sram_addr_ok_o,
   output logic        data_sram_data_ok_o,
   output logic [31:0] data_sram_rdata_o,
   output logic [3:0]  arid_o,
   output logic [31:0] araddr_o,
   output logic [7:0]  arlen_o,
   output logic [2:0]  arsize_o,
   output logic [1:0]  arburst_o,
   output logic [1:0]  arlock_o,
   output logic [3:0]  arcache_o,
   output logic [2:0]  arprot_o,
   output logic        arvalid_o,
   input  logic        arready_i,
   input  logic [3:0]  rid_i,
   input  logic [31:0] rdata_i,
   input  logic [1:0]  rresp_i,
   input  logic        rlast_i,
   input  logic        rvalid_i,
   output logic        rready_o,
   output logic [3:0]  awid_o,
   output logic [31:0] awaddr_o,
   output logic [7:0]  awlen_o,
   output logic [2:0]  awsize_o,
   output logic [1:0]  awburst_o,
   output logic [1:0]  awlock_o,
   output logic [3:0]  awcache_o,
   output logic [2:0]  awprot_o,
   output logic        awvalid_o,
   input  logic        awready_i,
   output logic [3:0]  wid_o,
   output logic [31:0] wdata_o,
   output logic [3:0]  wstrb_o,
   output logic        wlast_o,
   output logic        wvalid_o,
   input  logic        wready_i,
   input  logic [3:0]  bid_i,
   input  logic [1:0]  bresp_i,
   input  logic        bvalid_i,
   output logic        bready_o
);
   typedef enum logic [1:0] {RD_IDLE, RD_AR, RD_R} rd_state_t;
   typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_RESP} wr_state_t;
   rd_state_t   rd_state_q;
   wr_state_t   wr_state_q;
   logic [31:0] araddr_q, awaddr_q, wdata_q;
   logic [2:0]  arsize_q, awsize_q;
   logic [3:0]  wstrb_q;
   logic        arid_q, rd_owner_q, arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
   logic        raw_inst, raw_data, data_busy, data_rd_go, inst_rd_go, wr_go, aw_done, w_done;
   logic        unused_ok;

   // a read is held off while it targets the word of a write still in flight
   always_comb begin
`ifdef RAW_CHECK_EN
      raw_inst = (wr_state_q != WR_IDLE) && (inst_sram_addr_i[31:2] == awaddr_q[31:2]);
      raw_data = (wr_state_q != WR_IDLE) && (data_sram_addr_i[31:2] == awaddr_q[31:2]);
`else
      raw_inst = 1'b0;
      raw_data = 1'b0;
`endif
   end

   assign data_busy  = (rd_state_q != RD_IDLE && rd_owner_q) || wr_state_q != WR_IDLE;
   assign data_rd_go = rd_state_q == RD_IDLE && data_sram_req_i && !data_sram_wr_i && !data_busy && !raw_data;
   assign inst_rd_go = rd_state_q == RD_IDLE && !data_rd_go && inst_sram_req_i && !raw_inst;
   assign wr_go      = wr_state_q == WR_IDLE && data_sram_req_i && data_sram_wr_i && !data_busy;
   assign aw_done    = !awvalid_q || awready_i;
   assign w_done     = !wvalid_q || wready_i;

   // read FSM: one outstanding read, data side granted ahead of inst side
   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_state_q <= RD_IDLE;
         araddr_q   <= '0;
         arsize_q   <= '0;
         arid_q     <= 1'b0;
         rd_owner_q <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
      end else begin
         case (rd_state_q)
            RD_IDLE: if (data_rd_go || inst_rd_go) begin
               araddr_q   <= data_rd_go ? data_sram_addr_i : inst_sram_addr_i;
               arsize_q   <= {1'b0, data_rd_go ? data_sram_size_i : inst_sram_size_i};
               arid_q     <= data_rd_go;
               rd_owner_q <= data_rd_go;
               arvalid_q  <= 1'b1;
               rd_state_q <= RD_AR;
            end
            RD_AR: if (arready_i) begin
               arvalid_q  <= 1'b0;
               rready_q   <= 1'b1;
               rd_state_q <= RD_R;
            end
            RD_R: if (rvalid_i) begin
               rready_q   <= 1'b0;
               rd_state_q <= RD_IDLE;
            end
            default: rd_state_q <= RD_IDLE;
         endcase
      end
   end

   // write FSM: data side only; AW and W handshake independently, then wait for B
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_state_q <= WR_IDLE;
         awaddr_q   <= '0;
         awsize_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         bready_q   <= 1'b0;
      end else begin
         case (wr_state_q)
            WR_IDLE: if (wr_go) begin
               awaddr_q   <= data_sram_addr_i;
               awsize_q   <= {1'b0, data_sram_size_i};
               wdata_q    <= data_sram_wdata_i;
               wstrb_q    <= data_sram_wstrb_i;
               awvalid_q  <= 1'b1;
               wvalid_q   <= 1'b1;
               wr_state_q <= WR_ADDR;
            end
            WR_ADDR: begin
               if (awready_i) awvalid_q <= 1'b0;
               if (wready_i) wvalid_q <= 1'b0;
               if (aw_done && w_done) begin
                  bready_q   <= 1'b1;
                  wr_state_q <= WR_RESP;
               end
            end
            WR_RESP: if (bvalid_i) begin
               bready_q   <= 1'b0;
               wr_state_q <= WR_IDLE;
            end
            default: wr_state_q <= WR_IDLE;
         endcase
      end
   end

   assign inst_sram_addr_ok_o = arvalid_q && arready_i && !rd_owner_q;
   assign data_sram_addr_ok_o = (arvalid_q && arready_i && rd_owner_q) || (wr_state_q == WR_ADDR && aw_done && w_done);
   assign inst_sram_data_ok_o = rready_q && rvalid_i && !rid_i[0];
   assign data_sram_data_ok_o = (rready_q && rvalid_i && rid_i[0]) || (bready_q && bvalid_i);
   assign inst_sram_rdata_o   = rdata_i;
   assign data_sram_rdata_o   = rdata_i;

   assign arid_o    = {3'b000, arid_q};
   assign araddr_o  = araddr_q;
   assign arlen_o   = 8'd0;
   assign arsize_o  = arsize_q;
   assign arburst_o = 2'b01;
   assign arlock_o  = 2'b00;
   assign arcache_o = 4'd0;
   assign arprot_o  = 3'd0;
   assign arvalid_o = arvalid_q;
   assign rready_o  = rready_q;

   assign awid_o    = 4'd1;
   assign awaddr_o  = awaddr_q;
   assign awlen_o   = 8'd0;
   assign awsize_o  = awsize_q;
   assign awburst_o = 2'b01;
   assign awlock_o  = 2'b00;
   assign awcache_o = 4'd0;
   assign awprot_o  = 3'd0;
   assign awvalid_o = awvalid_q;
   assign wid_o     = 4'd1;
   assign wdata_o   = wdata_q;
   assign wstrb_o   = wstrb_q;
   assign wlast_o   = 1'b1;
   assign wvalid_o  = wvalid_q;
   assign bready_o  = bready_q;

   assign unused_ok = ^{inst_sram_wr_i, inst_sram_wstrb_i, inst_sram_wdata_i, rid_i[3:1], rresp_i, rlast_i, bid_i, bresp_i};
endmodule
